// File: rtl/fft_pwr_peak.sv
// Streaming |X[k]|^2 power computation for FFT bins with per-frame peak search
// and bin-index sequence checking.
module fft_pwr_peak #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 9,
   parameter int SIG_MODE   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2*DATA_WIDTH-1:0] s_axi_data,
   input  logic [ADDR_WIDTH:0]     s_axi_addr,
   input  logic                    s_axi_valid,
   input  logic                    s_axi_last,
   output logic                    s_axi_ready,
   output logic [2*DATA_WIDTH:0]   m_pwr_data,
   output logic [ADDR_WIDTH:0]     m_pwr_addr,
   output logic                    m_pwr_last,
   output logic                    m_pwr_valid,
   input  logic                    m_pwr_ready,
   output logic                    peak_valid,
   output logic [ADDR_WIDTH:0]     peak_addr,
   output logic [2*DATA_WIDTH:0]   peak_pwr,
   output logic                    seq_err,
   input  logic                    err_clr
);
   localparam int DW  = DATA_WIDTH;
   localparam int AW1 = ADDR_WIDTH + 1;

   typedef enum logic {TRK_START, TRK_RUN} trk_state_t;

   logic [DW-1:0]   in_re, in_im;
   logic            ext_re, ext_im;
   logic [2*DW-1:0] re_x, im_x, re_sq, im_sq;
   logic            adv, in_hs, out_hs;

   logic            s1_full, s2_full, s1_last;
   logic [2*DW-1:0] s1_re_sq, s1_im_sq;
   logic [AW1-1:0]  s1_addr;

   trk_state_t      trk_state;
   logic [AW1-1:0]  trk_addr;
   logic [2*DW:0]   trk_pwr;
   logic            take;
   logic [AW1-1:0]  exp_idx;

   assign in_re = s_axi_data[DW-1:0];
   assign in_im = s_axi_data[2*DW-1:DW];

   // Operands widened to the full product width so -2^(DW-1) squares exactly.
   assign ext_re = (SIG_MODE != 0) & in_re[DW-1];
   assign ext_im = (SIG_MODE != 0) & in_im[DW-1];
   assign re_x   = {{DW{ext_re}}, in_re};
   assign im_x   = {{DW{ext_im}}, in_im};
   assign re_sq  = re_x * re_x;
   assign im_sq  = im_x * im_x;

   assign adv         = m_pwr_ready | ~m_pwr_valid | ~s2_full;
   assign s_axi_ready = adv;
   assign in_hs       = s_axi_valid & adv;
   assign out_hs      = m_pwr_valid & m_pwr_ready;
   assign m_pwr_valid = s2_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_full    <= 1'b0;
         s1_last    <= 1'b0;
         s1_re_sq   <= '0;
         s1_im_sq   <= '0;
         s1_addr    <= '0;
         s2_full    <= 1'b0;
         m_pwr_last <= 1'b0;
         m_pwr_data <= '0;
         m_pwr_addr <= '0;
      end else if (adv) begin
         s1_full <= s_axi_valid;
         if (s_axi_valid) begin
            s1_re_sq <= re_sq;
            s1_im_sq <= im_sq;
            s1_addr  <= s_axi_addr;
            s1_last  <= s_axi_last;
         end
         s2_full    <= s1_full;
         m_pwr_last <= s1_full & s1_last;
         if (s1_full) begin
            m_pwr_data <= {1'b0, s1_re_sq} + {1'b0, s1_im_sq};
            m_pwr_addr <= s1_addr;
         end
      end
   end

   // Strict compare keeps the earliest bin on ties.
   assign take = (trk_state == TRK_START) | (m_pwr_data > trk_pwr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trk_state  <= TRK_START;
         trk_addr   <= '0;
         trk_pwr    <= '0;
         peak_valid <= 1'b0;
         peak_addr  <= '0;
         peak_pwr   <= '0;
      end else begin
         peak_valid <= out_hs & m_pwr_last;
         if (out_hs) begin
            if (take) begin
               trk_addr <= m_pwr_addr;
               trk_pwr  <= m_pwr_data;
            end
            trk_state <= m_pwr_last ? TRK_START : TRK_RUN;
            if (m_pwr_last) begin
               peak_addr <= take ? m_pwr_addr : trk_addr;
               peak_pwr  <= take ? m_pwr_data : trk_pwr;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_idx <= '0;
         seq_err <= 1'b0;
      end else begin
         if (in_hs) exp_idx <= s_axi_last ? '0 : exp_idx + AW1'(1);
         if (in_hs && (s_axi_addr != exp_idx)) seq_err <= 1'b1;
         else if (err_clr)                     seq_err <= 1'b0;
      end
   end

endmodule

// File: doc/fft_pwr_peak.md
FFT_PWR_PEAK -- requirements
Module: fft_pwr_peak

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the width of each real/imag component.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 9; the bin index is ADDR_WIDTH+1 bits wide.
REQ-003 The block SHALL have parameter SIG_MODE, default 1; 1 means components are signed, 0 means unsigned.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port s_axi_data, input, 2*DATA_WIDTH bits: FFT bin in the form {im, re}.
REQ-007 The block SHALL have port s_axi_addr, input, ADDR_WIDTH+1 bits: index of the FFT bin.
REQ-008 The block SHALL have ports s_axi_valid (input, 1 bit), s_axi_last (input, 1 bit) and s_axi_ready (output, 1 bit): the upstream stream handshake.
REQ-009 The block SHALL have port m_pwr_data, output, 2*DATA_WIDTH+1 bits: re^2+im^2, unsigned.
REQ-010 The block SHALL have ports m_pwr_addr (output, ADDR_WIDTH+1 bits), m_pwr_last (output, 1 bit), m_pwr_valid (output, 1 bit) and m_pwr_ready (input, 1 bit): the downstream power stream.
REQ-011 The block SHALL have ports peak_valid (output, 1 bit), peak_addr (output, ADDR_WIDTH+1 bits) and peak_pwr (output, 2*DATA_WIDTH+1 bits): the per-frame peak result.
REQ-012 The block SHALL have ports seq_err (output, 1 bit, sticky) and err_clr (input, 1 bit).

Function
REQ-013 The block SHALL implement a 2-stage pipeline: stage 1 registers re*re and im*im; stage 2 registers their sum together with addr and last.
REQ-014 Products SHALL be full width: 2*DATA_WIDTH bits for each product and 2*DATA_WIDTH+1 bits for the sum, with no truncation or rounding.
REQ-015 When SIG_MODE=1 the operands SHALL be treated as two's complement; -2^(DW-1) squared SHALL be exact.
REQ-016 The pipeline SHALL advance only when adv = m_pwr_ready | ~m_pwr_valid | ~stage2_full.
REQ-017 s_axi_ready SHALL equal adv, combinationally.
REQ-018 When no stage holds stale data, a sample SHALL be accepted on s_axi_valid&s_axi_ready.
REQ-019 Latency SHALL be 2 cycles from input handshake to m_pwr_valid when there is no backpressure; throughput SHALL be 1 sample per cycle.
REQ-020 While m_pwr_valid=1 and m_pwr_ready=0, m_pwr_data, m_pwr_addr and m_pwr_last SHALL hold stable, and no sample SHALL be lost or duplicated.
REQ-021 Pipeline bubbles (s_axi_valid=0) SHALL propagate as m_pwr_valid=0 and SHALL NOT alter the peak tracker.
REQ-022 The peak tracker SHALL update only on an output handshake (m_pwr_valid&m_pwr_ready).
REQ-023 The first handshake of a frame SHALL load the tracker unconditionally; a frame starts after reset or after the handshake carrying m_pwr_last.
REQ-024 A later handshake SHALL replace the tracker only if its power is strictly greater; on a tie the earlier (lower-index) bin SHALL be kept.
REQ-025 On the handshake carrying m_pwr_last, peak_valid SHALL pulse high for exactly 1 cycle on the next cycle, with peak_addr and peak_pwr final and including that last sample.
REQ-026 peak_addr and peak_pwr SHALL hold their values until the next frame's peak_valid.
REQ-027 A frame of length 1 (last on the first sample) SHALL report that sample as the peak.
REQ-028 An expected-index counter SHALL reset to 0 at frame start and increment on each input handshake; it SHALL wrap to 0 after an accepted last.
REQ-029 If s_axi_addr differs from the expected index on an input handshake, seq_err SHALL be set on the next cycle; the data SHALL still be processed normally.
REQ-030 err_clr=1 SHALL clear seq_err on the next cycle; if err_clr and a new mismatch occur in the same cycle, set SHALL win.
REQ-031 If a new frame's first sample enters the pipeline while the previous frame's last sample is still in the pipeline, the frames SHALL be handled independently, with no cycle gap required.

Reset
REQ-032 rst_n=0 SHALL immediately (asynchronously) clear m_pwr_valid, m_pwr_last, peak_valid and seq_err, the stage-full flags, and the expected-index counter.
REQ-033 rst_n=0 SHALL clear m_pwr_data, m_pwr_addr, peak_addr and peak_pwr to 0, and set the tracker to the frame-start state.
REQ-034 During reset s_axi_ready SHALL be 1 (pipeline empty).
REQ-035 Reset asserted mid-frame SHALL discard all in-flight samples; no peak_valid SHALL be produced for the aborted frame.

Verification
REQ-036 Scenario: DW=16; send (re=3, im=-4) at addr 0 with last, m_pwr_ready=1. Required: m_pwr_data=25 two cycles later, then peak_valid one cycle after that, with peak_addr=0 and peak_pwr=25.
REQ-037 Scenario: send (re=-32768, im=-32768). Required: m_pwr_data=2^31 exactly.
REQ-038 Scenario: 8-bin frame with powers 1,9,4,9,0,0,0,2. Required: peak_addr=1, peak_pwr=9 (tie keeps the earlier bin).
REQ-039 Scenario: hold m_pwr_ready=0 for 5 cycles mid-frame while s_axi_valid stays 1. Required: s_axi_ready drops after the pipeline fills, outputs stay stable, and all 64 bins are output in order once.
REQ-040 Scenario: a frame's addr sequence is 0,1,3. Required: seq_err=1 from the cycle after the bad index until err_clr is applied.
REQ-041 Scenario: pulse rst_n=0 at bin 20 of a 64-bin frame, then send a fresh 4-bin frame. Required: no peak_valid for the aborted frame; the peak is reported for the new frame only.
